// File: rtl/hes_pkg.sv
// rtl/hes_pkg.sv - shared types and default sizes for the stream scheduler
package hes_pkg;

    localparam int DEF_NUM_CH   = 4;
    localparam int DEF_CORE_LAT = 1;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/hes_stream_sched_if.sv
// rtl/hes_stream_sched_if.sv - requester, cipher core and response bundle
interface hes_stream_sched_if #(
    parameter int NUM_CH = 4
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]   req_valid;
    logic [NUM_CH-1:0]   req_first;
    logic [NUM_CH-1:0]   req_last;
    logic [NUM_CH*8-1:0] req_key;
    logic [NUM_CH*8-1:0] req_data;
    logic [NUM_CH-1:0]   req_ready;

    logic                core_valid;
    logic                core_new_message;
    logic [7:0]          core_key;
    logic [7:0]          core_data;
    logic                core_out_valid;
    logic [7:0]          core_out_byte;

    logic                rsp_valid;
    logic [CH_W-1:0]     rsp_ch;
    logic [7:0]          rsp_byte;

    // master: requesters plus the cipher core's result side
    modport master (
        output req_valid, req_first, req_last, req_key, req_data,
        output core_out_valid, core_out_byte,
        input  req_ready, core_valid, core_new_message, core_key, core_data,
        input  rsp_valid, rsp_ch, rsp_byte
    );

    modport slave (
        input  req_valid, req_first, req_last, req_key, req_data,
        input  core_out_valid, core_out_byte,
        output req_ready, core_valid, core_new_message, core_key, core_data,
        output rsp_valid, rsp_ch, rsp_byte
    );

endinterface

// File: rtl/hes_rr_arbiter.sv
// rtl/hes_rr_arbiter.sv - round-robin pick starting one past the pointer
module hes_rr_arbiter #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    int c;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        c     = 0;
        for (int i = 1; i <= N; i++) begin
            c = (int'(ptr_i) + i) % N;
            if (!any_o && req_i[c]) begin
                any_o    = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = W'(c);
            end
        end
    end

endmodule

// File: rtl/hes_stream_sched.sv
// rtl/hes_stream_sched.sv - atomic per-message scheduler in front of a single-counter cipher core
// Optional HES_SCHED_STATS_EN adds msg_count/byte_count outputs.
module hes_stream_sched
    import hes_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int CORE_LAT = DEF_CORE_LAT,
    parameter int DRAIN_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    hes_stream_sched_if.slave  bus,
    output logic               busy
`ifdef HES_SCHED_STATS_EN
    ,
    output logic [15:0]        msg_count,
    output logic [15:0]        byte_count
`endif
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IF_W = $clog2(CORE_LAT + 1) + 1;

    state_t            state_q;
    logic [CH_W-1:0]   g_q;
    logic [CH_W-1:0]   ptr_q;
    byte_t             key_q;
    logic [IF_W-1:0]   inflight_q;
    logic [IF_W-1:0]   inflight_d;
    logic [CH_W-1:0]   tag_q [CORE_LAT];

    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] gnt_oh;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_any;
    byte_t             sel_key;
    logic              issue;
    logic              g_last;

    assign elig = bus.req_valid & bus.req_first;

    hes_rr_arbiter #(
        .N (NUM_CH),
        .W (CH_W)
    ) u_arb (
        .req_i (elig),
        .ptr_i (ptr_q),
        .gnt_o (gnt_oh),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    always_comb begin
        sel_key = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_oh[i]) sel_key = bus.req_key[i*8 +: 8];
        end
    end

    // Only the granted channel is ever looked at once a message is open.
    assign issue  = (state_q == ST_STREAM) && bus.req_valid[g_q];
    assign g_last = bus.req_last[g_q];

    assign bus.req_ready        = issue ? (NUM_CH'(1) << g_q) : '0;
    assign bus.core_valid       = issue || (state_q == ST_LOAD);
    assign bus.core_new_message = (state_q == ST_LOAD);
    assign bus.core_key         = key_q;
    assign bus.core_data        = issue ? bus.req_data[g_q*8 +: 8] : 8'h00;

    assign bus.rsp_valid = bus.core_out_valid;
    assign bus.rsp_byte  = bus.core_out_byte;
    assign bus.rsp_ch    = tag_q[CORE_LAT-1];

    assign busy = (state_q != ST_IDLE);

    always_comb begin
        inflight_d = inflight_q;
        if (issue && !bus.core_out_valid) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!issue && bus.core_out_valid && (inflight_q != '0)) begin
            inflight_d = inflight_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            g_q        <= '0;
            ptr_q      <= CH_W'(NUM_CH - 1);
            key_q      <= '0;
            inflight_q <= '0;
            for (int i = 0; i < CORE_LAT; i++) tag_q[i] <= '0;
        end else begin
            inflight_q <= inflight_d;
            tag_q[0]   <= issue ? g_q : '0;
            for (int i = 1; i < CORE_LAT; i++) tag_q[i] <= tag_q[i-1];
            case (state_q)
                ST_IDLE: begin
                    if (gnt_any) begin
                        g_q     <= gnt_idx;
                        ptr_q   <= gnt_idx;
                        key_q   <= sel_key;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD:   state_q <= ST_STREAM;
                ST_STREAM: begin
                    if (issue && g_last) state_q <= (DRAIN_EN != 0) ? ST_DRAIN : ST_IDLE;
                end
                ST_DRAIN: begin
                    if (inflight_q == '0) state_q <= ST_IDLE;
                end
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef HES_SCHED_STATS_EN
    logic [15:0] msg_count_q;
    logic [15:0] byte_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_count_q  <= '0;
            byte_count_q <= '0;
        end else if (issue) begin
            byte_count_q <= byte_count_q + 16'd1;
            if (g_last) msg_count_q <= msg_count_q + 16'd1;
        end
    end

    assign msg_count  = msg_count_q;
    assign byte_count = byte_count_q;
`endif

endmodule
